// File: rtl/mgt_01_divide_unit_pkg.sv
// mgt_01_divide_unit_pkg: shared enums for the RV32M divide unit
package mgt_01_divide_unit_pkg;
  typedef enum logic [1:0] {DIV_, DIVU_, REM_, REMU_} div_ops_e;
  typedef enum logic {FREE, BUSY} fu_state_e;
  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} div_fsm_e;
endpackage

// File: rtl/mgt_01_divide_unit.sv
// mgt_01_divide_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module mgt_01_divide_unit
  import mgt_01_divide_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  div_ops_e        operation_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output fu_state_e       fu_state_o
);
  localparam int CW = $clog2(XLEN);
  div_fsm_e state;
  div_ops_e op;
  logic [CW-1:0] cnt;
  logic a_neg, b_neg, spec, sgn, zero, ovf;
  logic [XLEN-1:0] rem, quo, dvs, a_mag, b_mag, q_fix, r_fix, res_fix;
  logic [XLEN:0] part, trial;
  assign fu_state_o = state == IDLE ? FREE : BUSY;
  always_comb begin
    sgn = operation_i == DIV_ || operation_i == REM_;
    a_mag = sgn && dividend_i[XLEN-1] ? -dividend_i : dividend_i;
    b_mag = sgn && divisor_i[XLEN-1] ? -divisor_i : divisor_i;
    zero = divisor_i == '0;
    ovf = sgn && dividend_i == {1'b1, {(XLEN-1){1'b0}}} && &divisor_i;
    part = {rem, quo[XLEN-1]};
    trial = part - {1'b0, dvs};
    q_fix = (a_neg ^ b_neg) && !spec ? -quo : quo;
    r_fix = a_neg && !spec ? -rem : rem;
    res_fix = op == DIV_ || op == DIVU_ ? q_fix : r_fix;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      op <= DIV_;
      cnt <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      spec <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result_o <= '0;
      valid_o <= 1'b0;
    end else if (clk_en_i) begin
      valid_o <= 1'b0;
      if (flush_i) state <= IDLE;
      else case (state)
        IDLE: if (valid_i) begin
          op <= operation_i;
          a_neg <= sgn && dividend_i[XLEN-1];
          b_neg <= sgn && divisor_i[XLEN-1];
          spec <= zero || ovf;
          dvs <= b_mag;
          cnt <= '0;
          quo <= zero ? '1 : ovf ? dividend_i : a_mag;
          rem <= zero ? dividend_i : '0;
          state <= zero || ovf ? FIX : DIVIDE;
        end
        DIVIDE: begin
          rem <= trial[XLEN] ? part[XLEN-1:0] : trial[XLEN-1:0];
          quo <= {quo[XLEN-2:0], !trial[XLEN]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result_o <= res_fix;
          valid_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mgt_01_divide_unit.sv
// tb_mgt_01_divide_unit: directed self-checking bench for the divide unit
module tb_mgt_01_divide_unit;
  import mgt_01_divide_unit_pkg::*;
  typedef struct {div_ops_e op; logic [31:0] a, b, r; int lat;} vec_t;
  logic clk = 1'b0, rst_n_i = 1'b0, clk_en_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0;
  logic [31:0] dividend_i = '0, divisor_i = '0, result_o;
  div_ops_e operation_i = DIV_;
  logic valid_o;
  fu_state_e fu_state_o;
  int nvec = 0, nerr = 0;
  vec_t dv [10];
  vec_t sv [8];
  mgt_01_divide_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
    .valid_i(valid_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .operation_i(operation_i), .result_o(result_o), .valid_o(valid_o),
    .fu_state_o(fu_state_o)
  );
  always #5 clk = ~clk;
  task automatic run_op(input bit now, input div_ops_e op, input logic [31:0] a, b,
                        output logic [31:0] r, output int lat);
    if (!now) @(negedge clk);
    valid_i = 1'b1; operation_i = op; dividend_i = a; divisor_i = b;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    r = result_o;
    if (!valid_o) lat = -1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    nvec++; if (result_o !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 0", result_o); end
    nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid_o); end
    nvec++; if (fu_state_o !== FREE) begin nerr++; $display("FAIL reset_state got %0d want FREE", fu_state_o); end
    rst_n_i = 1'b1;
  endtask
  task automatic test_divide;
    logic [31:0] r;
    int lat;
    dv = '{'{DIV_, 32'd20, 32'd3, 32'd6, 33}, '{REM_, 32'd20, 32'd3, 32'd2, 33},
           '{DIV_, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33}, '{REM_, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33},
           '{DIVU_, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33}, '{DIV_, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
           '{REM_, 32'd7, 32'hFFFFFFFE, 32'd1, 33}, '{DIV_, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'd6, 33},
           '{REM_, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'hFFFFFFFE, 33}, '{REMU_, 32'hFFFFFFFF, 32'd10, 32'd5, 33}};
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, dv[i].op, dv[i].a, dv[i].b, r, lat);
      nvec++; if (r !== dv[i].r) begin nerr++; $display("FAIL divide[%0d] result got %h want %h", i, r, dv[i].r); end
      nvec++; if (lat != dv[i].lat) begin nerr++; $display("FAIL divide[%0d] latency got %0d want %0d", i, lat, dv[i].lat); end
      @(negedge clk);
      nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL divide[%0d] pulse got %b want 0", i, valid_o); end
    end
  endtask
  task automatic test_special;
    logic [31:0] r;
    int lat;
    sv = '{'{DIV_, 32'd5, 32'd0, 32'hFFFFFFFF, 1}, '{REMU_, 32'd5, 32'd0, 32'd5, 1},
           '{REM_, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1}, '{DIVU_, 32'd5, 32'd0, 32'hFFFFFFFF, 1},
           '{DIV_, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1}, '{REM_, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1},
           '{DIVU_, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33}, '{DIV_, 32'h80000000, 32'd2, 32'hC0000000, 33}};
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, sv[i].op, sv[i].a, sv[i].b, r, lat);
      nvec++; if (r !== sv[i].r) begin nerr++; $display("FAIL special[%0d] result got %h want %h", i, r, sv[i].r); end
      nvec++; if (lat != sv[i].lat) begin nerr++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, sv[i].lat); end
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r;
    int lat;
    run_op(1'b0, DIV_, 32'd20, 32'd3, r, lat);
    nvec++; if (r !== 32'd6) begin nerr++; $display("FAIL b2b_first got %h want 6", r); end
    run_op(1'b1, DIVU_, 32'd9, 32'd3, r, lat);
    nvec++; if (r !== 32'd3) begin nerr++; $display("FAIL b2b_second got %h want 3", r); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL b2b_latency got %0d want 33", lat); end
  endtask
  task automatic test_clk_en;
    int tot;
    @(negedge clk);
    valid_i = 1'b1; operation_i = DIVU_; dividend_i = 32'd100; divisor_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    tot = 0;
    repeat (5) begin @(negedge clk); tot++; end
    nvec++; if (fu_state_o !== BUSY) begin nerr++; $display("FAIL clken_busy got %0d want BUSY", fu_state_o); end
    clk_en_i = 1'b0; valid_i = 1'b1; operation_i = DIV_; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) begin @(negedge clk); tot++; end
    clk_en_i = 1'b1;
    repeat (3) begin @(negedge clk); tot++; end
    valid_i = 1'b0;
    while (!valid_o && tot < 200) begin @(negedge clk); tot++; end
    nvec++; if (result_o !== 32'd14) begin nerr++; $display("FAIL clken_result got %h want 14", result_o); end
    nvec++; if (tot != 43) begin nerr++; $display("FAIL clken_latency got %0d want 43", tot); end
    clk_en_i = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (valid_o !== 1'b1) begin nerr++; $display("FAIL clken_hold_valid got %b want 1", valid_o); end
    clk_en_i = 1'b1;
    @(negedge clk);
    nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL clken_release got %b want 0", valid_o); end
  endtask
  task automatic test_flush;
    logic [31:0] r;
    int lat, seen;
    @(negedge clk);
    valid_i = 1'b1; operation_i = DIV_; dividend_i = 32'd100; divisor_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (12) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    nvec++; if (fu_state_o !== FREE) begin nerr++; $display("FAIL flush_state got %0d want FREE", fu_state_o); end
    nvec++; if (result_o !== 32'd14) begin nerr++; $display("FAIL flush_hold got %h want 14", result_o); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o) seen++; end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL flush_no_valid got %0d want 0", seen); end
    valid_i = 1'b1; flush_i = 1'b1; operation_i = DIV_; dividend_i = 32'd9; divisor_i = 32'd3;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    nvec++; if (fu_state_o !== FREE) begin nerr++; $display("FAIL flush_priority got %0d want FREE", fu_state_o); end
    run_op(1'b0, DIV_, 32'd9, 32'd3, r, lat);
    nvec++; if (r !== 32'd3) begin nerr++; $display("FAIL flush_after got %h want 3", r); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] r;
    int lat, seen;
    @(negedge clk);
    valid_i = 1'b1; operation_i = DIVU_; dividend_i = 32'd100; divisor_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    nvec++; if (result_o !== 32'h0) begin nerr++; $display("FAIL rstmid_result got %h want 0", result_o); end
    nvec++; if (fu_state_o !== FREE) begin nerr++; $display("FAIL rstmid_state got %0d want FREE", fu_state_o); end
    @(negedge clk);
    rst_n_i = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o) seen++; end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL rstmid_no_valid got %0d want 0", seen); end
    run_op(1'b0, DIV_, 32'd9, 32'd3, r, lat);
    nvec++; if (r !== 32'd3) begin nerr++; $display("FAIL rstmid_after got %h want 3", r); end
  endtask
  initial begin
    test_reset;
    test_divide;
    test_special;
    test_back_to_back;
    test_clk_en;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mgt_01_divide_unit.md
Name: mgt_01_divide_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the inverse counterpart of the multiply unit.
- Sits beside the multiply unit in the arithmetic cluster and exposes the same functional-unit state output to the issue logic.
- Not pipelined: one operation in flight at a time, one quotient bit per enabled cycle, for minimum area.

Parameters:
- XLEN, 32, operand and result width in bits. Must be at least 4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  clock enable. When low, every register holds its value.
- flush_i  in  1  synchronous abort of the operation in flight.
- valid_i  in  1  request. Operands and operation are accepted when valid_i=1, clk_en_i=1 and fu_state_o=FREE.
- dividend_i  in  XLEN  rs1 value.
- divisor_i  in  XLEN  rs2 value.
- operation_i  in  div_ops_e  selects DIV_, DIVU_, REM_ or REMU_.
- result_o  out  XLEN  registered result.
- valid_o  out  1  one-enabled-cycle pulse marking result_o as valid.
- fu_state_o  out  fu_state_e  FREE in IDLE, BUSY otherwise.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - state=IDLE, counter=0, all datapath registers=0.
  - result_o=0, valid_o=0, fu_state_o=FREE.
  - Reset asserted mid-operation abandons the operation; no valid_o is produced.
- Accept (edge A, in IDLE):
  - Latch the operation.
  - Latch operand magnitudes: absolute values for DIV_/REM_, raw values for DIVU_/REMU_.
  - Latch both operand sign bits.
  - Inputs are ignored while BUSY.
- State machine:
  - IDLE -> DIVIDE on a normal accept.
  - IDLE -> FIX on a special-case accept.
  - DIVIDE -> FIX after the XLEN-th iteration.
  - FIX -> IDLE unconditionally.
- DIVIDE: XLEN iterations on edges A+1..A+XLEN, one per enabled edge.
  - trial = {rem[XLEN-1:0], quo[XLEN-1]} - divisor, computed XLEN+1 bits wide.
  - If trial is non-negative: rem=trial and shift 1 into quo.
  - Otherwise: shift the partial remainder left, bring in the next dividend bit, and shift 0 into quo.
  - The 5-bit counter runs 0..XLEN-1.
- FIX (edge A+XLEN+1):
  - Quotient is negated for signed ops when the operand signs differ.
  - Remainder is negated for signed ops when the dividend is negative.
  - Select quotient (DIV_/DIVU_) or remainder (REM_/REMU_) and register it into result_o.
  - Set valid_o=1.
- Latency:
  - Normal: valid_o is high for the cycle after edge A+XLEN+1, i.e. 33 enabled cycles for XLEN=32.
  - Special case: valid_o is high for the cycle after edge A+1.
- valid_o is cleared on the next enabled edge. A new accept is legal in the same cycle that valid_o is high.
- Special cases (resolved in FIX, no iterations):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend; remainder = 0.
- clk_en_i=0: the FSM, counter, result_o and valid_o all freeze. valid_o stays high until the next enabled edge.
- flush_i=1 on an enabled edge:
  - Any state goes to IDLE, valid_o=0, result_o is held.
  - flush_i has priority over a simultaneous accept.
- Width rules:
  - The trial subtraction is XLEN+1 bits, so there is no loss for unsigned magnitudes up to 2^XLEN-1.
  - Absolute value of -2^(XLEN-1) is handled as an unsigned magnitude.

Decomposition:
- Instruction_pkg.svh: add typedef enum div_ops_e {DIV_, DIVU_, REM_, REMU_}.
- Modules_pkg.svh: reuse the existing fu_state_e. Add typedef enum div_fsm_e {IDLE, DIVIDE, FIX}.
- No sub-module. The datapath step is small enough to stay inline in a single always_comb block.

Test Plan:
- DIV 20 / 3 -> valid_o after 33 cycles, result_o=6. Repeat as REM -> 2.
- DIV -7 / 2 -> -3 (0xFFFFFFFD). REM -7 / 2 -> -1. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIV 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. Both with valid_o 2 cycles after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. Both via the 2-cycle fast path.
- Start DIVU 100 / 7:
  - Hold clk_en_i=0 for 10 cycles mid-run -> result 14, valid_o delayed by exactly 10 cycles.
  - Change the inputs while BUSY -> no effect on the result.
- Flush and reset:
  - Assert flush_i at iteration 12 -> FREE next cycle, no valid_o. A following DIV 9 / 3 -> 3.
  - Assert rst_n_i low mid-run -> outputs 0 immediately (asynchronous).
